// File: rtl/player_action_arbiter.sv
// Shares one game_logic action port among up to four players: edge-detects button
// presses, holds one pending action per player and issues them round-robin.
module player_action_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int DROP_W      = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 num_players,
    input  logic [5*NUM_PLAYERS-1:0]   btn_in,
    output logic                       act_valid,
    input  logic                       act_ready,
    output logic [1:0]                 act_player,
    output logic [2:0]                 act_code,
    output logic [NUM_PLAYERS-1:0]     pending,
    output logic [DROP_W-1:0]          drop_count
);

    localparam logic [1:0] LAST_INIT = 2'(NUM_PLAYERS - 1);

    logic [5*NUM_PLAYERS-1:0] btn_q_reg;
    logic [5*NUM_PLAYERS-1:0] rise;
    logic [3*NUM_PLAYERS-1:0] press_code;
    logic [NUM_PLAYERS-1:0]   enabled;
    logic [NUM_PLAYERS-1:0]   press;
    logic [NUM_PLAYERS-1:0]   freed;
    logic [NUM_PLAYERS-1:0]   drop_vec;
    logic [NUM_PLAYERS-1:0]   slot_full_reg;
    logic [2:0]               slot_code_reg [NUM_PLAYERS];
    logic [1:0]               last_grant_reg;
    logic                     load_en;
    logic                     grant_valid;
    logic [1:0]               grant_id;
    logic [2:0]               grant_code;
    logic [DROP_W-1:0]        drop_next;
    int                       cand;

    assign rise    = btn_in & ~btn_q_reg;
    assign load_en = !act_valid || act_ready;
    assign pending = slot_full_reg;

    // Multiple simultaneous rises collapse to one code: chop > left > right > up > down.
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        logic [4:0] rise_p;
        assign rise_p                = rise[5*gi +: 5];
        assign enabled[gi]           = (num_players >= 2'(gi));
        assign press_code[3*gi +: 3] = rise_p[4] ? 3'd5 :
                                       rise_p[0] ? 3'd1 :
                                       rise_p[1] ? 3'd2 :
                                       rise_p[2] ? 3'd3 :
                                       rise_p[3] ? 3'd4 : 3'd0;
        assign press[gi]    = enabled[gi] && (rise_p != 5'd0);
        assign freed[gi]    = grant_valid && (grant_id == 2'(gi));
        assign drop_vec[gi] = press[gi] && slot_full_reg[gi] && !freed[gi];
    end

    // Round-robin scan starting just after the last granted player.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 2'd0;
        grant_code  = 3'd0;
        cand        = 0;
        if (load_en) begin
            for (int i = 1; i <= NUM_PLAYERS; i++) begin
                cand = (int'(last_grant_reg) + i) % NUM_PLAYERS;
                for (int j = 0; j < NUM_PLAYERS; j++) begin
                    if (!grant_valid && cand == j && slot_full_reg[j] && enabled[j]) begin
                        grant_valid = 1'b1;
                        grant_id    = 2'(j);
                        grant_code  = slot_code_reg[j];
                    end
                end
            end
        end
    end

    always_comb begin
        drop_next = drop_count;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (drop_vec[j] && drop_next != {DROP_W{1'b1}}) begin
                drop_next = drop_next + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_full_reg <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                slot_code_reg[p] <= 3'd0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (!enabled[p]) begin
                    slot_full_reg[p] <= 1'b0;
                end else if (press[p] && (!slot_full_reg[p] || freed[p])) begin
                    slot_full_reg[p] <= 1'b1;
                    slot_code_reg[p] <= press_code[3*p +: 3];
                end else if (freed[p]) begin
                    slot_full_reg[p] <= 1'b0;
                end
            end
        end
    end

    // btn_q resets high so buttons held through reset never look like fresh presses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_valid      <= 1'b0;
            act_player     <= 2'd0;
            act_code       <= 3'd0;
            last_grant_reg <= LAST_INIT;
            btn_q_reg      <= '1;
            drop_count     <= '0;
        end else begin
            btn_q_reg  <= btn_in;
            drop_count <= drop_next;
            if (grant_valid) begin
                act_valid      <= 1'b1;
                act_player     <= grant_id;
                act_code       <= grant_code;
                last_grant_reg <= grant_id;
            end else if (act_ready) begin
                act_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_action_arbiter.sv
// Randomized and directed bench for player_action_arbiter with a slot/queue reference model.
module tb_player_action_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    num_players;
    logic [5*N-1:0] btn_in;
    logic          act_valid;
    logic          act_ready;
    logic [1:0]    act_player;
    logic [2:0]    act_code;
    logic [N-1:0]  pending;
    logic [DW-1:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    bit         m_valid;
    int         m_player, m_code, m_last, m_drop;
    bit         m_full [N];
    int         m_slot [N];
    logic [5*N-1:0] m_prev;

    player_action_arbiter #(.NUM_PLAYERS(N), .DROP_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .num_players(num_players),
        .btn_in     (btn_in),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .act_player (act_player),
        .act_code   (act_code),
        .pending    (pending),
        .drop_count (drop_count)
    );

    always #20 clock = ~clock;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Code for a set of simultaneous rising buttons: chop wins, else lowest bit.
    function automatic int encode(logic [4:0] r);
        if (r[4]) return 5;
        for (int b = 0; b < 4; b++) if (r[b]) return b + 1;
        return 0;
    endfunction

    function automatic int pend_vec();
        int v = 0;
        for (int p = 0; p < N; p++) if (m_full[p]) v |= (1 << p);
        return v;
    endfunction

    function automatic bit any_full();
        return pend_vec() != 0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_player = 0; m_code = 0; m_last = N - 1; m_drop = 0;
        for (int p = 0; p < N; p++) begin m_full[p] = 0; m_slot[p] = 0; end
        m_prev = '1;
        exp_q.delete();
    endtask

    task automatic model_step();
        int g = -1;
        int np = int'(num_players);
        logic [5*N-1:0] r;
        if (!m_valid || act_ready) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (g < 0 && m_full[c] && c <= np) g = c;
            end
        end
        if (g >= 0) begin
            m_valid = 1; m_player = g; m_code = m_slot[g]; m_last = g;
            m_full[g] = 0;
            exp_q.push_back({2'(g), 3'(m_code)});
        end else if (act_ready) begin
            m_valid = 0;
        end
        r = btn_in & ~m_prev;
        for (int p = 0; p < N; p++) begin
            int code;
            code = encode(r[5*p +: 5]);
            if (p > np) m_full[p] = 0;
            else if (code != 0) begin
                if (!m_full[p]) begin m_full[p] = 1; m_slot[p] = code; end
                else if (m_drop < 255) m_drop++;
            end
        end
        m_prev = btn_in;
    endtask

    always @(posedge clock) begin
        if (!reset) model_reset();
        else model_step();
    end

    always @(negedge reset) model_reset();

    always @(negedge clock) begin
        if (reset) begin
            check("act_valid", int'(act_valid), int'(m_valid));
            if (m_valid) begin
                check("act_player", int'(act_player), m_player);
                check("act_code", int'(act_code), m_code);
            end
            check("pending", int'(pending), pend_vec());
            check("drop_count", int'(drop_count), m_drop);
            if (act_valid && act_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL xfer_unexpected: got player=%0d code=%0d expected none", act_player, act_code);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("xfer_player", int'(act_player), int'(e[4:3]));
                    check("xfer_code", int'(act_code), int'(e[2:0]));
                    $display("xfer player=%0d code=%0d", act_player, act_code);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    initial begin
        num_players = 2'd3; btn_in = '0; act_ready = 1'b1;
        tick(3);
        check("rst_valid", int'(act_valid), 0);
        check("rst_player", int'(act_player), 0);
        check("rst_code", int'(act_code), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_drop", int'(drop_count), 0);
        reset = 1'b1;

        // single player, one press held
        tick(2); num_players = 2'd0;
        btn_in[0] = 1'b1;
        tick(2);
        check("t1_valid", int'(act_valid), 1);
        check("t1_player", int'(act_player), 0);
        check("t1_code", int'(act_code), 1);
        tick(1);
        check("t1_one_cycle", int'(act_valid), 0);
        tick(5); btn_in = '0; tick(2);

        // all players chop together
        num_players = 2'd3;
        btn_in[4] = 1'b1; btn_in[9] = 1'b1; btn_in[14] = 1'b1; btn_in[19] = 1'b1;
        tick(6);
        check("t2_pending", int'(pending), 0);
        btn_in = '0; tick(2);

        // backpressure hold
        act_ready = 1'b0; btn_in[12] = 1'b1;
        tick(12);
        check("t3_valid", int'(act_valid), 1);
        check("t3_player", int'(act_player), 2);
        check("t3_code", int'(act_code), 3);
        act_ready = 1'b1; tick(1);
        check("t3_dropped", int'(act_valid), 0);
        btn_in = '0; tick(2);

        // disabled player and in-cycle priority
        num_players = 2'd1; btn_in[19] = 1'b1;
        tick(3);
        check("t5_no_act", int'(act_valid), 0);
        check("t5_drop", int'(drop_count), 0);
        btn_in[19] = 1'b0; btn_in[0] = 1'b1; btn_in[4] = 1'b1;
        tick(2);
        check("t5_player", int'(act_player), 0);
        check("t5_code", int'(act_code), 5);
        btn_in = '0; tick(2);

        // drops and saturation
        num_players = 2'd3; act_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin btn_in[5] = 1'b1; tick(1); btn_in[5] = 1'b0; tick(1); end
        tick(1);
        check("t4_drop1", int'(drop_count), 1);
        for (int k = 0; k < 300; k++) begin btn_in[5] = 1'b1; tick(1); btn_in[5] = 1'b0; tick(1); end
        check("t4_sat", int'(drop_count), 255);
        btn_in[5] = 1'b1; tick(1); btn_in[5] = 1'b0; tick(1);
        check("t4_sat_hold", int'(drop_count), 255);
        act_ready = 1'b1; tick(4);

        // asynchronous reset mid-operation
        act_ready = 1'b0;
        btn_in[4] = 1'b1; btn_in[9] = 1'b1; btn_in[19] = 1'b1;
        tick(2);
        btn_in[4] = 1'b0; btn_in[9] = 1'b0; btn_in[19] = 1'b0; tick(1);
        btn_in[4] = 1'b1; btn_in[9] = 1'b1; btn_in[19] = 1'b1; tick(1);
        check("t6_pending", int'(pending), 11);
        check("t6_valid", int'(act_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", int'(act_valid), 0);
        check("t6_async_pending", int'(pending), 0);
        check("t6_async_drop", int'(drop_count), 0);
        check("t6_async_code", int'(act_code), 0);
        tick(2); reset = 1'b1; act_ready = 1'b1;
        tick(5);
        check("t6_no_act", int'(act_valid), 0);

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < 5*N; b++) if ($urandom_range(0, 5) == 0) btn_in[b] = ~btn_in[b];
            act_ready = ($urandom_range(0, 3) != 0);
            if (!any_full() && $urandom_range(0, 49) == 0) num_players = 2'($urandom_range(0, 3));
            tick(1);
        end

        act_ready = 1'b1;
        tick(10);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/player_action_arbiter.md
Name: player_action_arbiter

Overview:
Shares the single game_logic action input among up to four players: local buttons and, later, remote players from the communication link. It edge-detects each player's debounced button levels and encodes each press into an action code. Each player has a one-deep pending slot, and a round-robin scheduler issues one action at a time to game_logic over a valid/ready handshake. The block sits between the debounce/comm inputs and game_logic in top_level.

Parameters:
NUM_PLAYERS, 4, number of requester ports (1..4)
DROP_W, 8, width of saturating dropped-event counter

Ports:
clock  in  1  system clock (25 MHz pixel clock)
reset  in  1  asynchronous, active-low reset
num_players  in  2  highest enabled player ID; player p enabled iff p <= num_players
btn_in  in  5*NUM_PLAYERS  clean button levels per player p at [5p+4:5p] = {chop,down,up,right,left}
act_valid  out  1  action presented to game_logic
act_ready  in  1  game_logic accepts action this cycle
act_player  out  2  player ID of presented action
act_code  out  3  1=left 2=right 3=up 4=down 5=chop
pending  out  NUM_PLAYERS  per-player slot-full flags
drop_count  out  DROP_W  presses lost because the slot was full, saturating

Behaviour:
- Reset (reset low, async assert):
  - act_valid=0, act_player=0, act_code=0, pending=0, drop_count=0.
  - last_grant=NUM_PLAYERS-1, so player 0 wins first.
  - btn_q (previous button sample) resets to all ones, so buttons held through reset do not fire.
- Release of reset is synchronous to clock.
- Edge detect: rise = btn_in & ~btn_q, combinational. btn_q <= btn_in every cycle.
- Per-player encode: if multiple rises occur in one cycle, one action is taken and the rest are discarded without counting as drops. Priority is chop > left > right > up > down.
- Slot update per enabled player p, each edge:
  - Slot freed this cycle (p granted into the output register) or slot empty, and a press occurs: slot loads the code, pending[p]=1.
  - Slot full, not freed, and a press occurs: press dropped; drop_count += 1, saturating at all ones.
  - Freed and no press: pending[p]=0.
- Disabled player (p > num_players): slot forced empty, presses ignored and not counted.
  - num_players reduced mid-run: affected slots clear on the next edge.
  - An action already in the output register stays until accepted.
- Output register load: when act_valid==0 or act_ready==1, scan pending players starting at last_grant+1, modulo NUM_PLAYERS.
  - First pending player g wins: act_player<=g, act_code<=slot[g], act_valid<=1, slot[g] cleared, last_grant<=g.
  - No pending player: act_valid<=0 if the current action was accepted; otherwise hold.
- Handshake:
  - While act_valid=1 and act_ready=0, act_player and act_code are held stable.
  - Transfer occurs on a cycle with act_valid & act_ready. Back-to-back transfers at one per cycle are supported.
- Latency: a button level first sampled high at edge k sets the slot at edge k. act_valid rises at edge k+1 if the output register is free.
- Fairness: with all slots continuously refilled, grants cycle 0,1,2,3,0,… over enabled players. No player waits more than NUM_PLAYERS-1 grants.
- Width rules: act_player is zero-extended for NUM_PLAYERS<4. drop_count never wraps.

Test Plan:
1. Reset, num_players=0, player0 left 0→1, act_ready=1 → after one cycle act_valid=1, act_player=0, act_code=1 for exactly one cycle. Holding the button produces no further action.
2. num_players=3; all four players press chop in the same cycle; act_ready=1 → four consecutive valid cycles with act_player 0,1,2,3, all act_code=5. pending returns to 0.
3. Backpressure: act_ready=0, player2 presses up → act_valid=1, act_player=2, act_code=3, held stable for 10 cycles. When act_ready=1, the transfer occurs and act_valid drops next cycle.
4. Drops: act_ready=0, player1 makes 3 separate presses after the first is latched into output, so the slot holds the second press and the third is dropped → drop_count=1. Forcing 300 drops → drop_count=255, stays 255.
5. Disabled/priority: num_players=1, player3 presses → no action, drop_count unchanged. Player0 presses left+chop in the same cycle → act_code=5 only.
6. Reset mid-operation: pending=4'b1011 and act_valid=1, assert reset low asynchronously → all outputs 0 before the next edge. With buttons still held through reset release → no actions issued.
